// File: rtl/serial_pkg.sv
// Shared definitions for the serial front-end stages (feeder, detector, and later blocks).
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } feeder_state_t;

    localparam logic IDLE_BIT = 1'b0;

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: takes WIDTH-bit words over valid/ready and drives one bit per
// clock on x, with optional idle gap cycles between words.
module serial_bit_feeder #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned GAP       = 0,
    parameter bit          IDLE_BIT  = serial_pkg::IDLE_BIT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             x,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit
);

    localparam int unsigned         BCNT_W    = $clog2(WIDTH);
    localparam logic [BCNT_W-1:0]   BCNT_LAST = BCNT_W'(WIDTH - 1);
    localparam logic [3:0]          GCNT_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    serial_pkg::feeder_state_t state_q, state_d;
    logic [WIDTH-1:0]          sreg_q, sreg_d;
    logic [BCNT_W-1:0]         bcnt_q, bcnt_d;
    logic [3:0]                gcnt_q, gcnt_d;
    logic                      x_d, bit_valid_d, first_bit_d, last_bit_d;

    logic                      word_end;
    logic                      handshake;
    logic                      shift_bit;
    logic [WIDTH-1:0]          sreg_shifted;

    assign word_end  = (bcnt_q == BCNT_LAST);
    assign handshake = load_valid && load_ready;

    // Bit selection and shift direction fixed by MSB_FIRST
    always_comb begin
        if (MSB_FIRST) begin
            shift_bit    = sreg_q[WIDTH-1];
            sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shift_bit    = sreg_q[0];
            sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    // Ready is a pure decode of state and counters, held low while in reset
    always_comb begin
        load_ready = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                serial_pkg::IDLE:  load_ready = 1'b1;
                serial_pkg::SHIFT: load_ready = (GAP == 0) && word_end;
                serial_pkg::GAP:   load_ready = (gcnt_q == GCNT_LAST);
                default:           load_ready = 1'b0;
            endcase
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bcnt_d      = bcnt_q;
        gcnt_d      = gcnt_q;
        x_d         = IDLE_BIT;
        bit_valid_d = 1'b0;
        first_bit_d = 1'b0;
        last_bit_d  = 1'b0;

        unique case (state_q)
            serial_pkg::IDLE: begin
                if (handshake) begin
                    state_d = serial_pkg::SHIFT;
                    sreg_d  = load_data;
                    bcnt_d  = '0;
                end
            end

            serial_pkg::SHIFT: begin
                x_d         = shift_bit;
                bit_valid_d = 1'b1;
                first_bit_d = (bcnt_q == '0);
                last_bit_d  = word_end;
                sreg_d      = sreg_shifted;
                bcnt_d      = bcnt_q + BCNT_W'(1);
                if (word_end) begin
                    bcnt_d = '0;
                    if (GAP == 0) begin
                        // Reload on the final bit keeps the stream bubble-free
                        if (handshake) begin
                            sreg_d = load_data;
                        end else begin
                            state_d = serial_pkg::IDLE;
                        end
                    end else begin
                        state_d = serial_pkg::GAP;
                        gcnt_d  = '0;
                    end
                end
            end

            serial_pkg::GAP: begin
                gcnt_d = gcnt_q + 4'd1;
                if (gcnt_q == GCNT_LAST) begin
                    gcnt_d = '0;
                    if (handshake) begin
                        state_d = serial_pkg::SHIFT;
                        sreg_d  = load_data;
                        bcnt_d  = '0;
                    end else begin
                        state_d = serial_pkg::IDLE;
                    end
                end
            end

            default: begin
                state_d = serial_pkg::IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= serial_pkg::IDLE;
            sreg_q    <= '0;
            bcnt_q    <= '0;
            gcnt_q    <= '0;
            x         <= IDLE_BIT;
            bit_valid <= 1'b0;
            first_bit <= 1'b0;
            last_bit  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bcnt_q    <= bcnt_d;
            gcnt_q    <= gcnt_d;
            x         <= x_d;
            bit_valid <= bit_valid_d;
            first_bit <= first_bit_d;
            last_bit  <= last_bit_d;
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: MSB-first/GAP=0, LSB-first, and GAP=3 instances.
module tb_serial_bit_feeder;

    logic       clock;
    logic       reset_n;

    logic       valid_m, ready_m, x_m, bv_m, fb_m, lb_m;
    logic [7:0] data_m;
    logic       valid_l, ready_l, x_l, bv_l, fb_l, lb_l;
    logic [7:0] data_l;
    logic       valid_g, ready_g, x_g, bv_g, fb_g, lb_g;
    logic [7:0] data_g;

    int n_checks = 0;
    int n_pass   = 0;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_BIT(1'b0)) u_msb (
        .clock(clock), .reset_n(reset_n), .load_valid(valid_m), .load_ready(ready_m),
        .load_data(data_m), .x(x_m), .bit_valid(bv_m), .first_bit(fb_m), .last_bit(lb_m)
    );

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0), .IDLE_BIT(1'b0)) u_lsb (
        .clock(clock), .reset_n(reset_n), .load_valid(valid_l), .load_ready(ready_l),
        .load_data(data_l), .x(x_l), .bit_valid(bv_l), .first_bit(fb_l), .last_bit(lb_l)
    );

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(3), .IDLE_BIT(1'b0)) u_gap (
        .clock(clock), .reset_n(reset_n), .load_valid(valid_g), .load_ready(ready_g),
        .load_data(data_g), .x(x_g), .bit_valid(bv_g), .first_bit(fb_g), .last_bit(lb_g)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_m(input logic [7:0] d);
        data_m  = d;
        valid_m = 1'b1;
        tick();
        valid_m = 1'b0;
        data_m  = 8'h00;
    endtask

    task automatic collect_m(output logic [7:0] xs, output logic [7:0] bvs,
                             output logic [7:0] fbs, output logic [7:0] lbs);
        xs = '0; bvs = '0; fbs = '0; lbs = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            xs  = {xs[6:0], x_m};
            bvs = {bvs[6:0], bv_m};
            fbs = {fbs[6:0], fb_m};
            lbs = {lbs[6:0], lb_m};
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  xs, bvs, fbs, lbs;
        logic [15:0] s16, v16;
        logic [8:0]  s9, v9;
        logic [19:0] gx, gv, gf, gl;
        int          hs_at;

        reset_n = 1'b0;
        valid_m = 1'b0; data_m = 8'h00;
        valid_l = 1'b0; data_l = 8'h00;
        valid_g = 1'b0; data_g = 8'h00;

        // Reset state
        tick(); tick();
        check("rst x",         32'(x_m),     32'd0);
        check("rst bit_valid", 32'(bv_m),    32'd0);
        check("rst first_bit", 32'(fb_m),    32'd0);
        check("rst last_bit",  32'(lb_m),    32'd0);
        check("rst ready",     32'(ready_m), 32'd0);
        reset_n = 1'b1;
        #1;
        check("post-rst ready", 32'(ready_m), 32'd1);

        // Single word 8'hC3, MSB first
        send_m(8'hC3);
        check("c3 ready busy", 32'(ready_m), 32'd0);
        collect_m(xs, bvs, fbs, lbs);
        check("c3 x",         32'(xs),  32'hC3);
        check("c3 bit_valid", 32'(bvs), 32'hFF);
        check("c3 first_bit", 32'(fbs), 32'h80);
        check("c3 last_bit",  32'(lbs), 32'h01);
        tick();
        check("c3 idle x",     32'(x_m),     32'd0);
        check("c3 idle bv",    32'(bv_m),    32'd0);
        check("c3 idle ready", 32'(ready_m), 32'd1);

        // Back-to-back A5 then 5A with valid held
        data_m  = 8'hA5;
        valid_m = 1'b1;
        tick();
        data_m = 8'h5A;
        s16 = '0; v16 = '0;
        for (int j = 1; j <= 16; j++) begin
            check($sformatf("b2b ready %0d", j), 32'(ready_m), 32'((j == 8) || (j == 16)));
            tick();
            if (j == 8) valid_m = 1'b0;
            s16 = {s16[14:0], x_m};
            v16 = {v16[14:0], bv_m};
        end
        check("b2b stream",    32'(s16), 32'hA55A);
        check("b2b bit_valid", 32'(v16), 32'hFFFF);
        tick();
        check("b2b end bv", 32'(bv_m), 32'd0);

        // LSB first, 8'h01
        data_l  = 8'h01;
        valid_l = 1'b1;
        tick();
        valid_l = 1'b0;
        s9 = '0; v9 = '0;
        for (int j = 0; j < 9; j++) begin
            tick();
            s9 = {s9[7:0], x_l};
            v9 = {v9[7:0], bv_l};
        end
        check("lsb x",         32'(s9), 32'h100);
        check("lsb bit_valid", 32'(v9), 32'h1FE);

        // GAP=3 with two words queued
        data_g  = 8'hF0;
        valid_g = 1'b1;
        tick();
        data_g = 8'h0F;
        hs_at = 0;
        gx = '0; gv = '0; gf = '0; gl = '0;
        for (int j = 1; j <= 20; j++) begin
            if (valid_g && ready_g) hs_at = j;
            tick();
            if (hs_at == j) valid_g = 1'b0;
            gx = {gx[18:0], x_g};
            gv = {gv[18:0], bv_g};
            gf = {gf[18:0], fb_g};
            gl = {gl[18:0], lb_g};
        end
        check("gap handshake edge", 32'(hs_at), 32'd11);
        check("gap x",         32'(gx), 32'hF001E);
        check("gap bit_valid", 32'(gv), 32'hFF1FE);
        check("gap first_bit", 32'(gf), 32'h80100);
        check("gap last_bit",  32'(gl), 32'h01002);

        // Reset on bit 4 of 8'hFF, with a word offered during reset
        send_m(8'hFF);
        for (int j = 0; j < 4; j++) tick();
        check("mid bit4 x", 32'(x_m), 32'd1);
        reset_n = 1'b0;
        data_m  = 8'h55;
        valid_m = 1'b1;
        #1;
        check("mid rst ready", 32'(ready_m), 32'd0);
        tick();
        check("mid rst x",       32'(x_m),     32'd0);
        check("mid rst bv",      32'(bv_m),    32'd0);
        check("mid rst ready2",  32'(ready_m), 32'd0);
        tick();
        valid_m = 1'b0;
        reset_n = 1'b1;
        #1;
        check("mid rel ready", 32'(ready_m), 32'd1);
        tick();
        check("mid no accept bv", 32'(bv_m), 32'd0);
        send_m(8'h80);
        collect_m(xs, bvs, fbs, lbs);
        check("mid 80 x",  32'(xs),  32'h80);
        check("mid 80 bv", 32'(bvs), 32'hFF);

        // Valid pulsed while busy must not disturb the word in flight
        send_m(8'h96);
        xs = '0;
        for (int j = 1; j <= 8; j++) begin
            if (j == 3) begin
                data_m  = 8'h3C;
                valid_m = 1'b1;
                #1;
                check("pulse ready low", 32'(ready_m), 32'd0);
            end
            tick();
            if (j == 3) begin
                valid_m = 1'b0;
                data_m  = 8'hFF;
            end
            xs = {xs[6:0], x_m};
        end
        check("pulse word intact", 32'(xs), 32'h96);
        tick();
        check("pulse idle bv", 32'(bv_m), 32'd0);
        send_m(8'hE7);
        collect_m(xs, bvs, fbs, lbs);
        check("pulse next word", 32'(xs), 32'hE7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-to-serial front end for the single-bit sequence detector stage. Accepts WIDTH-bit words over a valid/ready handshake and drives them out one bit per clock on `x`. `x` connects directly to the detector's serial input, which samples every clock. Between words, `x` holds a programmable idle level, and `bit_valid` marks cycles that carry real data.

## Interface
- `WIDTH`, 8: word length in bits, ≥2.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.
- `GAP`, 0: idle cycles inserted after each word, 0..15.
- `IDLE_BIT`, 0: level driven on `x` when no data bit is being sent.
- `clock`: input, 1. Single clock; all logic on the rising edge.
- `reset_n`: input, 1. Synchronous, active-low reset, sampled on the rising edge of `clock`.
- `load_valid`: input, 1. Upstream has a word on `load_data`.
- `load_ready`: output, 1. Feeder accepts a word this cycle.
- `load_data`: input, WIDTH. Word to serialise; sampled only on handshake.
- `x`: output, 1. Registered serial bit to the detector.
- `bit_valid`: output, 1. Registered; `x` carries a data bit this cycle.
- `first_bit`: output, 1. Registered; high with the first bit of each word.
- `last_bit`: output, 1. Registered; high with the final bit of each word.

## Operation
- A handshake occurs on any rising edge where `load_valid` and `load_ready` are both high. `load_data` is copied into the internal shift register `sreg`, and the bit counter `bcnt` is cleared.
- FSM states:
  - IDLE: `load_ready`=1. On handshake, go to SHIFT.
  - SHIFT: each cycle, present the next bit, advance `sreg` by one, and increment `bcnt`.
    - When `bcnt`==WIDTH-1 and GAP==0: `load_ready`=1. On handshake, stay in SHIFT and reload. With no handshake, go to IDLE.
    - When `bcnt`==WIDTH-1 and GAP>0: go to GAP and clear `gcnt`.
  - GAP: `x`=IDLE_BIT and `bit_valid`=0. Increment `gcnt`.
    - When `gcnt`==GAP-1: `load_ready`=1. On handshake, go to SHIFT. With no handshake, go to IDLE.
- `load_ready` is a combinational decode of state and counters. It is never high during reset.
- Shift direction:
  - MSB_FIRST=1: shift left, output `sreg[WIDTH-1]`.
  - MSB_FIRST=0: shift right, output `sreg[0]`.
- `bcnt` is $clog2(WIDTH) bits wide and never exceeds WIDTH-1. `gcnt` is 4 bits wide and never exceeds GAP-1.
- Outside SHIFT, `x`=IDLE_BIT, and `bit_valid`, `first_bit`, `last_bit` are all 0.
- `load_data` changes without a handshake are ignored. A word is never truncated or repeated.

## Timing
- Reset values (`reset_n`=0 at an edge): state=IDLE, `x`=IDLE_BIT, `bit_valid`=0, `first_bit`=0, `last_bit`=0, `sreg`=0, `bcnt`=0, `gcnt`=0.
- Latency: for a handshake at edge N, the first bit is on `x` after edge N+1. The last bit is on `x` after edge N+WIDTH.
- With GAP=0 and continuous `load_valid`: zero-bubble streaming, one word every WIDTH cycles, `bit_valid` stays high continuously.
- With GAP=G: the next handshake can occur no earlier than WIDTH+G edges after the previous one.
- Reset mid-word: the word is abandoned with no further data bits. The next cycle shows `x`=IDLE_BIT and `bit_valid`=0. A word presented during reset is not accepted.
- `load_valid` dropping mid-word has no effect on the word already accepted.

## Structure
- Shared package `serial_pkg`: FSM state enum `feeder_state_t` {IDLE, SHIFT, GAP} and the `IDLE_BIT` default constant. The detector and future serial stages reuse both.
- Single module; no sub-module is needed. The shift register and both counters are inline.

## Test plan
- Reset release, then load 8'hC3 with MSB_FIRST=1, GAP=0.
  - `x` = 1,1,0,0,0,0,1,1 on cycles 1–8 after the handshake.
  - `first_bit` high on cycle 1 only; `last_bit` high on cycle 8 only.
  - The downstream detector's `y` goes high after the second 1, after the 0-0 pairs, and after the final 1-1.
- Back-to-back words 8'hA5 then 8'h5A, GAP=0, `load_valid` held high.
  - 16 consecutive cycles with `bit_valid`=1: 1010_0101_0101_1010.
  - `load_ready` high only in IDLE and on the 8th bit.
- MSB_FIRST=0, load 8'h01: `x` = 1,0,0,0,0,0,0,0, then IDLE_BIT.
- GAP=3, two words queued.
  - Exactly 3 cycles with `bit_valid`=0 and `x`=IDLE_BIT between word 1's `last_bit` and word 2's `first_bit`.
- `reset_n` asserted on bit 4 of 8'hFF.
  - Next cycle: `x`=0 and `bit_valid`=0; `load_ready`=0 while in reset.
  - After release: `load_ready`=1, and the new word 8'h80 yields 1,0,0,0,0,0,0,0.
- `load_valid` pulsed with `load_ready`=0 mid-word.
  - No acceptance; the word in flight is unchanged; `load_data` is sampled only at the next real handshake.
